// File: rtl/pio_in_pkg.sv
// pio_in_pkg: register offsets and mode encodings shared by the input-capture PIO
package pio_in_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_RSVD    = 2'd2,
        ADDR_EDGECAP = 2'd3
    } addr_e;

    localparam int EDGE_NONE    = 0;
    localparam int EDGE_RISING  = 1;
    localparam int EDGE_FALLING = 2;
    localparam int EDGE_ANY     = 3;

    localparam int IRQ_NONE  = 0;
    localparam int IRQ_LEVEL = 1;
    localparam int IRQ_EDGE  = 2;

endpackage

// File: rtl/pio_in_if.sv
// pio_in_if: Avalon-MM slave bus plus irq for the input-capture PIO
//   address/chipselect/write_n/writedata: master -> slave
//   readdata/irq: slave -> master
interface pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_sync.sv
// pio_in_sync: WIDTH-wide, STAGES-deep input synchroniser with synchronous reset
//   clk, reset: clock and active-high synchronous reset
//   d: asynchronous inputs; q: synchronised outputs (last stage)
module pio_in_sync #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) stage <= '0;
        else       stage <= {stage[STAGES-2:0], d};
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM input PIO with edge capture, irq mask and irq
//   clk, reset: clock and active-high synchronous reset
//   in_port: asynchronous external inputs
//   bus: slave side of pio_in_if (address, chipselect, write_n, writedata, readdata, irq)
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1,
    parameter int IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    pio_in_if.slave          bus
);

    // Warm-up ends once SYNC_STAGES+1 edges have passed since reset, so the
    // synchroniser filling with a static input never looks like an edge.
    localparam logic [2:0] WARM_END = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] d_sync, d_prev, edge_raw, edge_det, clr, rd_next;
    logic [WIDTH-1:0] irqmask, edgecapture, wdata;
    logic [2:0]       warm;
    logic             wr;

    pio_in_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (d_sync)
    );

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = |bus.writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        edge_raw = EDGE_TYPE == EDGE_RISING  ? d_sync & ~d_prev :
                   EDGE_TYPE == EDGE_FALLING ? ~d_sync & d_prev :
                   EDGE_TYPE == EDGE_ANY     ? d_sync ^ d_prev  : '0;
        edge_det = warm == WARM_END ? edge_raw : '0;
        clr      = wr && bus.address == ADDR_EDGECAP ? wdata : '0;
        rd_next  = bus.address == ADDR_DATA    ? d_sync      :
                   bus.address == ADDR_IRQMASK ? irqmask     :
                   bus.address == ADDR_EDGECAP ? edgecapture : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_prev       <= '0;
            warm         <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            bus.readdata <= '0;
        end else begin
            d_prev <= d_sync;
            if (warm != WARM_END) warm <= warm + 3'd1;
            if (wr && bus.address == ADDR_IRQMASK) irqmask <= wdata;
            // OR-ing the new edges after the clear lets a set win over a clear
            edgecapture  <= (edgecapture & ~clr) | edge_det;
            bus.readdata <= 32'(rd_next);
        end
    end

    assign bus.irq = IRQ_TYPE == IRQ_LEVEL ? |(d_sync & irqmask) :
                     IRQ_TYPE == IRQ_EDGE  ? |(edgecapture & irqmask) : 1'b0;

endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: scoreboard bench for three pio_in_capture configurations
module tb_pio_in_capture;
    import pio_in_pkg::*;

    localparam int NI = 3;
    localparam int PW [NI] = '{12, 32, 8};
    localparam int PS [NI] = '{2, 3, 2};
    localparam int PE [NI] = '{EDGE_RISING, EDGE_ANY, EDGE_FALLING};
    localparam int PI [NI] = '{IRQ_EDGE, IRQ_LEVEL, IRQ_NONE};

    typedef struct packed {
        logic [NI-1:0][31:0] rd;
        logic [NI-1:0]       irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_s;
    logic [1:0]  addr_s [NI];
    logic        cs_s   [NI];
    logic        wn_s   [NI];
    logic [31:0] wd_s   [NI];
    logic [31:0] in_s   [NI];
    logic [31:0] rd_o   [NI];
    logic        irq_o  [NI];

    logic [31:0] hist   [NI][4];
    logic [31:0] ecap_m [NI];
    logic [31:0] mask_m [NI];
    logic [31:0] rd_m   [NI];
    int          age    [NI];

    exp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    pio_in_if bus0 ();
    pio_in_if bus1 ();
    pio_in_if bus2 ();

    assign bus0.address = addr_s[0];
    assign bus0.chipselect = cs_s[0];
    assign bus0.write_n = wn_s[0];
    assign bus0.writedata = wd_s[0];
    assign bus1.address = addr_s[1];
    assign bus1.chipselect = cs_s[1];
    assign bus1.write_n = wn_s[1];
    assign bus1.writedata = wd_s[1];
    assign bus2.address = addr_s[2];
    assign bus2.chipselect = cs_s[2];
    assign bus2.write_n = wn_s[2];
    assign bus2.writedata = wd_s[2];
    assign rd_o[0] = bus0.readdata;
    assign rd_o[1] = bus1.readdata;
    assign rd_o[2] = bus2.readdata;
    assign irq_o[0] = bus0.irq;
    assign irq_o[1] = bus1.irq;
    assign irq_o[2] = bus2.irq;

    pio_in_capture #(.WIDTH(12), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_EDGE)) dut0 (
        .clk(clk), .reset(rst_s), .in_port(in_s[0][11:0]), .bus(bus0));
    pio_in_capture #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_LEVEL)) dut1 (
        .clk(clk), .reset(rst_s), .in_port(in_s[1]), .bus(bus1));
    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALLING), .IRQ_TYPE(IRQ_NONE)) dut2 (
        .clk(clk), .reset(rst_s), .in_port(in_s[2][7:0]), .bus(bus2));

    function automatic logic [31:0] wm(input int w);
        return w >= 32 ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
    endfunction

    // Reference: d_sync is the input sampled SYNC_STAGES-1 edges ago, d_prev the
    // one sampled SYNC_STAGES edges ago; edges count only from edge SYNC_STAGES+1
    // after reset; clears apply before new edges so a set wins.
    task automatic step(input int i, output logic irqv);
        logic [31:0] m, ds, dp, det, clr;
        logic        wr;
        m = wm(PW[i]);
        if (rst_s) begin
            for (int k = 0; k < 4; k++) hist[i][k] = '0;
            ecap_m[i] = '0;
            mask_m[i] = '0;
            rd_m[i]   = '0;
            age[i]    = 0;
        end else begin
            ds  = hist[i][PS[i]-1];
            dp  = hist[i][PS[i]];
            det = PE[i] == EDGE_RISING  ? ds & ~dp :
                  PE[i] == EDGE_FALLING ? ~ds & dp :
                  PE[i] == EDGE_ANY     ? ds ^ dp  : 32'h0;
            det = det & m;
            if (age[i] <= PS[i]) det = '0;
            wr = cs_s[i] && !wn_s[i];
            rd_m[i] = addr_s[i] == ADDR_DATA    ? ds        :
                      addr_s[i] == ADDR_IRQMASK ? mask_m[i] :
                      addr_s[i] == ADDR_EDGECAP ? ecap_m[i] : 32'h0;
            clr = (wr && addr_s[i] == ADDR_EDGECAP) ? wd_s[i] & m : 32'h0;
            ecap_m[i] = (ecap_m[i] & ~clr) | det;
            if (wr && addr_s[i] == ADDR_IRQMASK) mask_m[i] = wd_s[i] & m;
            for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = in_s[i] & m;
            if (age[i] < 1000) age[i]++;
        end
        irqv = PI[i] == IRQ_LEVEL ? |(hist[i][PS[i]-1] & mask_m[i]) :
               PI[i] == IRQ_EDGE  ? |(ecap_m[i] & mask_m[i]) : 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        logic iv;
        for (int i = 0; i < NI; i++) begin
            step(i, iv);
            e.rd[i]  = rd_m[i];
            e.irq[i] = iv;
        end
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] v);
        for (int i = 0; i < NI; i++) in_s[i] = v;
    endtask

    task automatic rd_all(input logic [1:0] a, input int n);
        for (int i = 0; i < NI; i++) begin
            addr_s[i] = a;
            cs_s[i]   = 1'b0;
            wn_s[i]   = 1'b1;
        end
        repeat (n) tick();
    endtask

    task automatic wr_all(input logic [1:0] a, input logic [31:0] d);
        for (int i = 0; i < NI; i++) begin
            addr_s[i] = a;
            cs_s[i]   = 1'b1;
            wn_s[i]   = 1'b0;
            wd_s[i]   = d;
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            cs_s[i] = 1'b0;
            wn_s[i] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, i, $time, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    chk("readdata", i, rd_o[i], e.rd[i]);
                    chk("irq", i, {31'h0, irq_o[i]}, {31'h0, e.irq[i]});
                end
            end
        end
    end

    initial begin
        rst_s = 1'b1;
        for (int i = 0; i < NI; i++) begin
            addr_s[i] = 2'd0;
            cs_s[i]   = 1'b0;
            wn_s[i]   = 1'b1;
            wd_s[i]   = '0;
        end
        set_in(32'hABC);
        rd_all(ADDR_DATA, 3);
        rst_s = 1'b0;
        rd_all(ADDR_DATA, 6);
        rd_all(ADDR_EDGECAP, 2);
        // bit0 rise then fall with irqmask=1
        wr_all(ADDR_IRQMASK, 32'h1);
        set_in(32'hABD);
        rd_all(ADDR_EDGECAP, 5);
        set_in(32'hABC);
        rd_all(ADDR_EDGECAP, 5);
        wr_all(ADDR_EDGECAP, 32'h1);
        rd_all(ADDR_EDGECAP, 2);
        // clear lands on the same edge as a new rising capture
        set_in(32'hABD);
        rd_all(ADDR_EDGECAP, 2);
        wr_all(ADDR_EDGECAP, 32'h1);
        rd_all(ADDR_EDGECAP, 3);
        wr_all(ADDR_EDGECAP, 32'h1);
        rd_all(ADDR_EDGECAP, 3);
        // level irq on bit 11
        wr_all(ADDR_IRQMASK, 32'h800);
        set_in(32'h2BD);
        rd_all(ADDR_DATA, 5);
        set_in(32'hABD);
        rd_all(ADDR_DATA, 5);
        wr_all(ADDR_IRQMASK, 32'h0);
        rd_all(ADDR_DATA, 2);
        wr_all(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd_all(ADDR_IRQMASK, 2);
        // fill edgecapture, then reset with everything set
        set_in(32'h0);
        rd_all(ADDR_EDGECAP, 5);
        set_in(32'hFFFF_FFFF);
        rd_all(ADDR_EDGECAP, 5);
        rst_s = 1'b1;
        rd_all(ADDR_EDGECAP, 2);
        rst_s = 1'b0;
        rd_all(ADDR_IRQMASK, 6);
        rd_all(ADDR_EDGECAP, 2);
        rd_all(ADDR_DATA, 2);
        // toggle all bits, writes to data and reserved offsets
        set_in(32'h0);
        rd_all(ADDR_EDGECAP, 5);
        wr_all(ADDR_DATA, 32'h1234_5678);
        wr_all(ADDR_RSVD, 32'hFFFF_FFFF);
        rd_all(ADDR_DATA, 2);
        rd_all(ADDR_RSVD, 2);
        rd_all(ADDR_EDGECAP, 2);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_s = ($urandom_range(299) == 0);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(3) == 0) in_s[i] = in_s[i] ^ ($urandom & $urandom & $urandom);
                addr_s[i] = 2'($urandom_range(3));
                cs_s[i]   = 1'($urandom_range(1));
                wn_s[i]   = ($urandom_range(2) != 0);
                wd_s[i]   = $urandom & $urandom;
            end
            tick();
        end
        rst_s = 1'b0;
        rd_all(ADDR_DATA, 2);
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pio_in_capture.md
# pio_in_capture

Parametrised Avalon-MM slave input port, successor to the fixed 12-bit read-only input PIO in the demo_de0 system. Synchronises a WIDTH-bit external input and exposes it as a readable data register. Adds per-bit edge capture with write-1-to-clear, and an interrupt-mask register driving a single level-sensitive irq line to the Nios II. Sits on the system interconnect beside the existing PIOs.

## Interface
- WIDTH, 12: input port width, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..3.
- EDGE_TYPE, 1: 0 none, 1 rising, 2 falling, 3 any.
- IRQ_TYPE, 1: 0 none (irq tied 0), 1 level (data & mask), 2 edge (edgecapture & mask).
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select: 0 data, 1 irqmask, 2 reserved, 3 edgecapture.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  interrupt request, active high.

## Operation
- Synchroniser: each in_port bit passes through SYNC_STAGES flops; last stage = d_sync. d_prev = d_sync delayed one cycle.
- Edge detect per bit: rising = d_sync & ~d_prev; falling = ~d_sync & d_prev; any = XOR. EDGE_TYPE 0: edgecapture constant 0.
- Warm-up counter: after reset deasserts, edge detection is masked for SYNC_STAGES+1 cycles. Inputs stable at reset exit therefore never produce a spurious capture. Counter saturates; it restarts only on reset.
- edgecapture[i] sets on a detected edge and holds until cleared. A write to address 3 with writedata[i]=1 clears bit i. Writing 0 leaves the bit unchanged.
- Simultaneous edge and clear on the same bit in the same cycle: set wins, bit stays 1.
- irqmask: read/write at address 1, WIDTH bits.
- Writes to addresses 0 and 2 are ignored.
- Write occurs when chipselect=1 and write_n=0.
- readdata is updated every cycle from the address mux (no read strobe, matching the existing PIO). address 0 -> d_sync; 1 -> irqmask; 2 -> 0; 3 -> edgecapture.
- irq is combinational from registers: IRQ_TYPE 1 -> |(d_sync & irqmask); 2 -> |(edgecapture & irqmask); 0 -> 0.
- Reset values: readdata 0, irq 0, irqmask 0, edgecapture 0, synchroniser and d_prev 0, warm-up counter 0.
- Reset mid-operation clears all state in the same edge, including pending captures and mask.

## Timing
- Read latency 1: readdata at edge t+1 reflects the address and register state at edge t.
- in_port change sampled at edge 0: d_sync updates at edge SYNC_STAGES-1 and is readable SYNC_STAGES edges later via readdata. Exact latency is SYNC_STAGES edges to d_sync plus 1 edge to readdata.
- Edge capture: edgecapture bit set at edge SYNC_STAGES (one edge after d_sync changes). Edge-mode irq is high in the same cycle.
- Level-mode irq follows d_sync with no added register.
- Write to irqmask or clear of edgecapture takes effect at the write edge. irq responds in the following cycle. readdata shows the new value one edge later.
- Pulses shorter than one clk period may be missed. This is not a requirement.

## Structure
- Package pio_in_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=3;
  - EDGE_NONE/RISING/FALLING/ANY constants;
  - IRQ_NONE/LEVEL/EDGE constants.
- Sub-module pio_in_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous reset, instantiated once.
- The top level holds the edge detect, warm-up counter, registers, read mux and irq.

## Test plan
- Reset, then in_port=12'hABC held: after SYNC_STAGES+2 cycles, a read of address 0 returns 32'h00000ABC. edgecapture reads 0 (warm-up suppresses the capture).
- EDGE_TYPE 1, IRQ_TYPE 2, irqmask=12'h001:
  - bit0 0->1: edgecapture=1 and irq=1 SYNC_STAGES+1 edges after the input change.
  - bit0 1->0: no new capture.
- Write 32'h1 to address 3 in the cycle bit0 has a new rising edge: edgecapture[0] remains 1. A clear in a later quiet cycle drops it and irq deasserts the next cycle.
- IRQ_TYPE 1, irqmask=12'h800, in_port[11] toggled: irq tracks d_sync[11]. Mask 0 forces irq=0. A write of 32'hFFFFFFFF to irqmask reads back 32'h00000FFF.
- Reset asserted while edgecapture=12'hFFF and irqmask=12'hFFF: next cycle irq=0, and all registers read 0 after release.
- EDGE_TYPE 3, WIDTH=32, SYNC_STAGES=3: toggling all bits sets edgecapture=32'hFFFFFFFF. Writes to addresses 0 and 2 have no effect.
